// File: rtl/cpu16_mem_responder.sv
// Memory-side responder for the cpu16 fetch and load/store ports.
// One shared single-port word RAM, round-robin arbitration, programmable wait states.
module cpu16_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ins_rd_addr,
  input  logic        ins_rd_req,
  output logic [15:0] ins_rd_data,
  output logic        ins_rd_rdy,
  input  logic [15:0] dat_rw_addr,
  input  logic [15:0] dat_wr_data,
  input  logic        dat_rd_req,
  input  logic        dat_wr_req,
  output logic [15:0] dat_rd_data,
  output logic        dat_rd_rdy,
  output logic        dat_wr_rdy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OP_IFETCH, OP_LOAD, OP_STORE} op_t;

  logic [15:0]   mem [DEPTH];
  state_t        state, state_nxt;
  op_t           op, op_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [15:0]   wdata, wdata_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_data, last_data_nxt;
  logic          access;
  logic          dat_req, grant_data;
  logic          ins_rdy_nxt, rd_rdy_nxt, wr_rdy_nxt;
  logic [15:0]   unused_addr_hi;

  // Address bits above the RAM index only alias; fold them away.
  assign unused_addr_hi = (ins_rd_addr >> AW) ^ (dat_rw_addr >> AW);

  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    cnt_nxt       = cnt;
    last_data_nxt = last_data;
    access        = 1'b0;
    ins_rdy_nxt   = 1'b0;
    rd_rdy_nxt    = 1'b0;
    wr_rdy_nxt    = 1'b0;
    dat_req       = dat_rd_req | dat_wr_req;
    // Data wins when alone or when instruction was served last.
    grant_data    = dat_req & (~ins_rd_req | ~last_data);

    case (state)
      IDLE: begin
        if (ins_rd_req | dat_req) begin
          state_nxt     = BUSY;
          last_data_nxt = grant_data;
          cnt_nxt       = CW'(WAIT_STATES);
          wdata_nxt     = dat_wr_data;
          if (grant_data) begin
            op_nxt   = dat_wr_req ? OP_STORE : OP_LOAD;
            addr_nxt = dat_rw_addr[AW-1:0];
          end else begin
            op_nxt   = OP_IFETCH;
            addr_nxt = ins_rd_addr[AW-1:0];
          end
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          access      = 1'b1;
          state_nxt   = RESP;
          ins_rdy_nxt = (op == OP_IFETCH);
          rd_rdy_nxt  = (op == OP_LOAD);
          wr_rdy_nxt  = (op == OP_STORE);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= OP_IFETCH;
      addr        <= '0;
      wdata       <= '0;
      cnt         <= '0;
      last_data   <= 1'b1;
      ins_rd_rdy  <= 1'b0;
      dat_rd_rdy  <= 1'b0;
      dat_wr_rdy  <= 1'b0;
      ins_rd_data <= '0;
      dat_rd_data <= '0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      addr       <= addr_nxt;
      wdata      <= wdata_nxt;
      cnt        <= cnt_nxt;
      last_data  <= last_data_nxt;
      ins_rd_rdy <= ins_rdy_nxt;
      dat_rd_rdy <= rd_rdy_nxt;
      dat_wr_rdy <= wr_rdy_nxt;
      if (access && op == OP_IFETCH) ins_rd_data <= mem[addr];
      if (access && op == OP_LOAD)   dat_rd_data <= mem[addr];
    end
  end

  // RAM is never reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && access && op == OP_STORE) mem[addr] <= wdata;
  end

endmodule

// File: tb/tb_cpu16_mem_responder.sv
// Directed bench for cpu16_mem_responder: one instance with no wait states, one with three.
module tb_cpu16_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data;
  logic        ins_rd_req, dat_rd_req, dat_wr_req;

  logic [15:0] ins_rd_data0, dat_rd_data0, ins_rd_data3, dat_rd_data3;
  logic        ins_rd_rdy0, dat_rd_rdy0, dat_wr_rdy0;
  logic        ins_rd_rdy3, dat_rd_rdy3, dat_wr_rdy3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu16_mem_responder #(.DEPTH(256), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset_n(reset_n),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
    .ins_rd_data(ins_rd_data0), .ins_rd_rdy(ins_rd_rdy0),
    .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data),
    .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
    .dat_rd_data(dat_rd_data0), .dat_rd_rdy(dat_rd_rdy0), .dat_wr_rdy(dat_wr_rdy0)
  );

  cpu16_mem_responder #(.DEPTH(256), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
    .clk(clk), .reset_n(reset_n),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
    .ins_rd_data(ins_rd_data3), .ins_rd_rdy(ins_rd_rdy3),
    .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data),
    .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
    .dat_rd_data(dat_rd_data3), .dat_rd_rdy(dat_rd_rdy3), .dat_wr_rdy(dat_wr_rdy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store together; returns cycles until rdy
  task automatic access(input int kind, input logic [15:0] a, input logic [15:0] d,
                        input bit slow, output int cyc);
    bit done;
    bit hit;
    done = 1'b0;
    cyc  = 0;
    ins_rd_addr = a;
    dat_rw_addr = a;
    dat_wr_data = d;
    ins_rd_req  = (kind == 0);
    dat_rd_req  = (kind == 1 || kind == 3);
    dat_wr_req  = (kind >= 2);
    for (int i = 1; i <= 40 && !done; i++) begin
      step();
      if (kind == 0) hit = slow ? ins_rd_rdy3 : ins_rd_rdy0;
      else           hit = slow ? (dat_rd_rdy3 | dat_wr_rdy3) : (dat_rd_rdy0 | dat_wr_rdy0);
      if (hit) begin
        done = 1'b1;
        cyc  = i;
      end
    end
    ins_rd_req = 1'b0;
    dat_rd_req = 1'b0;
    dat_wr_req = 1'b0;
    chk("rdy_timeout", 16'(done), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int npulse, nins, ndat;

    // Reset held with every request asserted
    reset_n = 1'b0;
    ins_rd_addr = 16'h0005; dat_rw_addr = 16'h0005; dat_wr_data = 16'hFFFF;
    ins_rd_req = 1'b1; dat_rd_req = 1'b1; dat_wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ins_rdy0", 16'(ins_rd_rdy0), 16'd0);
      chk("rst_rd_rdy0",  16'(dat_rd_rdy0), 16'd0);
      chk("rst_wr_rdy0",  16'(dat_wr_rdy0), 16'd0);
      chk("rst_wr_rdy3",  16'(dat_wr_rdy3), 16'd0);
    end
    chk("rst_ins_data0", ins_rd_data0, 16'h0000);
    chk("rst_dat_data0", dat_rd_data0, 16'h0000);
    chk("rst_ins_data3", ins_rd_data3, 16'h0000);
    chk("rst_dat_data3", dat_rd_data3, 16'h0000);
    ins_rd_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    reset_n = 1'b1;
    step();

    // Preload word 5, fetch it, then a load raised during RESP waits one extra cycle
    access(2, 16'h0005, 16'hBEEF, 1'b0, cyc);
    chk("st5_latency", 16'(cyc), 16'd2);
    chk("st5_wr_rdy", 16'(dat_wr_rdy0), 16'd1);
    step();
    chk("st5_wr_pulse", 16'(dat_wr_rdy0), 16'd0);
    access(0, 16'h0005, 16'h0000, 1'b0, cyc);
    chk("fetch_latency", 16'(cyc), 16'd2);
    chk("fetch_data", ins_rd_data0, 16'hBEEF);
    access(1, 16'h0005, 16'h0000, 1'b0, cyc);
    chk("b2b_latency", 16'(cyc), 16'd3);
    chk("b2b_data", dat_rd_data0, 16'hBEEF);
    chk("b2b_ins_rdy", 16'(ins_rd_rdy0), 16'd0);
    step();
    chk("b2b_rd_pulse", 16'(dat_rd_rdy0), 16'd0);

    // Store then load same address
    access(2, 16'h0012, 16'h1234, 1'b0, cyc);
    chk("st12_latency", 16'(cyc), 16'd2);
    step();
    access(1, 16'h0012, 16'h0000, 1'b0, cyc);
    chk("ld12_latency", 16'(cyc), 16'd2);
    chk("ld12_rd_rdy", 16'(dat_rd_rdy0), 16'd1);
    chk("ld12_wr_rdy", 16'(dat_wr_rdy0), 16'd0);
    chk("ld12_data", dat_rd_data0, 16'h1234);
    chk("ld12_ins_hold", ins_rd_data0, 16'hBEEF);
    step();
    chk("ld12_rd_pulse", 16'(dat_rd_rdy0), 16'd0);

    // Contention: both ports held for 24 cycles, instruction first
    ins_rd_addr = 16'h0005; dat_rw_addr = 16'h0012;
    ins_rd_req = 1'b1; dat_rd_req = 1'b1;
    npulse = 0; nins = 0; ndat = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ins_rd_rdy0 || dat_rd_rdy0) begin
        chk("cont_excl", 16'(ins_rd_rdy0 & dat_rd_rdy0), 16'd0);
        chk("cont_order", 16'(dat_rd_rdy0), 16'(npulse % 2));
        if (ins_rd_rdy0) begin
          nins++;
          chk("cont_ins_data", ins_rd_data0, 16'hBEEF);
        end else begin
          ndat++;
          chk("cont_dat_data", dat_rd_data0, 16'h1234);
        end
        npulse++;
      end
    end
    ins_rd_req = 1'b0; dat_rd_req = 1'b0;
    step();
    chk("cont_pulses", 16'(npulse), 16'd8);
    chk("cont_ins_cnt", 16'(nins), 16'd4);
    chk("cont_dat_cnt", 16'(ndat), 16'd4);

    // Address aliasing modulo 256
    access(2, 16'h0103, 16'hA5A5, 1'b0, cyc);
    chk("alias_st_rdy", 16'(dat_wr_rdy0), 16'd1);
    step();
    access(1, 16'h0003, 16'h0000, 1'b0, cyc);
    chk("alias_ld_data", dat_rd_data0, 16'hA5A5);
    step();

    // Load and store together: store only
    access(3, 16'h0020, 16'h5A5A, 1'b0, cyc);
    chk("both_latency", 16'(cyc), 16'd2);
    chk("both_wr_rdy", 16'(dat_wr_rdy0), 16'd1);
    chk("both_rd_rdy", 16'(dat_rd_rdy0), 16'd0);
    chk("both_rd_hold", dat_rd_data0, 16'hA5A5);
    step();
    chk("both_after_rd", 16'(dat_rd_rdy0), 16'd0);
    access(1, 16'h0020, 16'h0000, 1'b0, cyc);
    chk("both_readback", dat_rd_data0, 16'h5A5A);
    step();

    // Three wait states, fresh reset
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    access(2, 16'h0007, 16'h7777, 1'b1, cyc);
    chk("ws3_st_latency", 16'(cyc), 16'd5);
    chk("ws3_st_rdy", 16'(dat_wr_rdy3), 16'd1);
    step();
    chk("ws3_st_pulse", 16'(dat_wr_rdy3), 16'd0);
    access(1, 16'h0007, 16'h0000, 1'b1, cyc);
    chk("ws3_ld_latency", 16'(cyc), 16'd5);
    chk("ws3_ld_rdy", 16'(dat_rd_rdy3), 16'd1);
    chk("ws3_ld_data", dat_rd_data3, 16'h7777);
    step();
    chk("ws3_ld_pulse", 16'(dat_rd_rdy3), 16'd0);

    // Reset lands on the access edge of a store: no rdy, no write
    dat_rw_addr = 16'h0007; dat_wr_data = 16'hDEAD; dat_wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_busy_rdy", 16'(dat_wr_rdy3), 16'd0);
    end
    reset_n = 1'b0;
    dat_wr_req = 1'b0;
    step();
    chk("abort_rst_rdy", 16'(dat_wr_rdy3), 16'd0);
    reset_n = 1'b1;
    step();
    chk("abort_post_rdy", 16'(dat_wr_rdy3), 16'd0);
    access(1, 16'h0007, 16'h0000, 1'b1, cyc);
    chk("abort_latency", 16'(cyc), 16'd5);
    chk("abort_keep", dat_rd_data3, 16'h7777);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
